// File: rtl/wrr_burst_arbiter_if.sv
// Bus between requesters and the weighted round-robin burst arbiter.
// Handshake: a tenure starts when grant_valid rises and ends at the first cycle where done=1 while grant_valid=1.
interface wrr_burst_arbiter_if #(
    parameter int PORTS        = 4,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int IW = $clog2(PORTS);

    logic [PORTS-1:0]              request;
    logic                          done;
    logic [PORTS*WEIGHT_WIDTH-1:0] weight;
    logic [PORTS-1:0]              grant;
    logic                          grant_valid;
    logic [IW-1:0]                 grant_encoded;
    logic [WEIGHT_WIDTH-1:0]       burst_count;
    logic                          fsm_busy;

    modport master (
        output request, done, weight,
        input  grant, grant_valid, grant_encoded, burst_count, fsm_busy
    );

    modport slave (
        input  request, done, weight,
        output grant, grant_valid, grant_encoded, burst_count, fsm_busy
    );
endinterface

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: a port keeps the grant for up to max(weight,1)
// completed transactions, then the grant rotates with zero-bubble handoff.
module wrr_burst_arbiter #(
    parameter int PORTS        = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    wrr_burst_arbiter_if.slave bus
);
    localparam int IW = $clog2(PORTS);
    localparam logic [IW:0]        PORTS_W = (IW+1)'(PORTS);
    localparam logic [PORTS-1:0]   ONE_HOT0 = PORTS'(1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state_q;
    logic [PORTS-1:0]        grant_q;
    logic [IW-1:0]           enc_q;
    logic [IW-1:0]           ptr_q;
    logic [WEIGHT_WIDTH-1:0] cnt_q;

    logic [WEIGHT_WIDTH-1:0] w_arr [PORTS];
    logic [IW-1:0]           base;
    logic [IW:0]             cand;
    logic                    found;
    logic [IW-1:0]           next_idx;
    logic [PORTS-1:0]        grant_next;
    logic [WEIGHT_WIDTH:0]   eff_w;
    logic [WEIGHT_WIDTH:0]   cnt_next;
    logic                    keep;

    // Search starts one past the base and examines the base itself last;
    // while busy the base is the current owner, otherwise the saved pointer.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            w_arr[i] = bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
        base     = (state_q == BUSY) ? enc_q : ptr_q;
        cand     = '0;
        found    = 1'b0;
        next_idx = '0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = {1'b0, base} + (IW+1)'(i);
            if (cand >= PORTS_W) begin
                cand = cand - PORTS_W;
            end
            if (!found && bus.request[cand[IW-1:0]]) begin
                found    = 1'b1;
                next_idx = cand[IW-1:0];
            end
        end
        grant_next = ONE_HOT0 << next_idx;
        // Compare one bit wider so a full-scale weight never wraps the count.
        eff_w    = (w_arr[enc_q] == '0) ? (WEIGHT_WIDTH+1)'(1) : {1'b0, w_arr[enc_q]};
        cnt_next = {1'b0, cnt_q} + (WEIGHT_WIDTH+1)'(1);
        keep     = bus.request[enc_q] && (cnt_next < eff_w);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            enc_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= IW'(PORTS-1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= BUSY;
                        grant_q <= grant_next;
                        enc_q   <= next_idx;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (bus.done) begin
                        if (keep) begin
                            cnt_q <= cnt_next[WEIGHT_WIDTH-1:0];
                        end else begin
                            ptr_q <= enc_q;
                            cnt_q <= '0;
                            if (found) begin
                                grant_q <= grant_next;
                                enc_q   <= next_idx;
                            end else begin
                                state_q <= IDLE;
                                grant_q <= '0;
                                enc_q   <= '0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = (state_q == BUSY);
    assign bus.grant_encoded = enc_q;
    assign bus.burst_count   = cnt_q;
    assign bus.fsm_busy      = (state_q == BUSY);
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed and random checks of wrr_burst_arbiter with PORTS=4, WEIGHT_WIDTH=4.
module tb_wrr_burst_arbiter;
    localparam int PORTS = 4;
    localparam int WW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic mon_en      = 1'b0;

    wrr_burst_arbiter_if #(.PORTS(PORTS), .WEIGHT_WIDTH(WW)) bus ();

    wrr_burst_arbiter #(.PORTS(PORTS), .WEIGHT_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic gv,
                             input logic [1:0] enc, input logic [3:0] bc);
        check({tag, "_grant"}, bus.grant, g);
        check({tag, "_gv"}, bus.grant_valid, gv);
        check({tag, "_enc"}, bus.grant_encoded, enc);
        check({tag, "_bc"}, bus.burst_count, bc);
    endtask

    // Cycle-level invariant monitor, sampled on the falling edge.
    logic       p_rst = 1'b0, p_valid = 1'b0, p_done = 1'b0;
    logic [3:0] p_req = '0, p_grant = '0, p_bc = '0;
    logic [1:0] p_enc = '0;
    logic [3:0] enc_seen = '0;
    int         wait_cnt [PORTS];
    logic       new_ten;

    initial for (int i = 0; i < PORTS; i++) wait_cnt[i] = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot0", 32'($onehot0(bus.grant)), 1);
            check("gv_is_or", bus.grant_valid, |bus.grant);
            if (bus.grant_valid) begin
                check("grant_vs_enc", bus.grant, 4'b0001 << bus.grant_encoded);
                enc_seen[bus.grant_encoded] = 1'b1;
            end else begin
                check("idle_enc", bus.grant_encoded, 0);
                check("idle_bc", bus.burst_count, 0);
            end
            if (!p_rst) begin
                check("reset_gv", bus.grant_valid, 0);
            end else if (p_valid && !p_done) begin
                check("hold_grant", bus.grant, p_grant);
                check("hold_enc", bus.grant_encoded, p_enc);
                check("hold_bc", bus.burst_count, p_bc);
            end
            new_ten = p_rst && bus.grant_valid && (!p_valid || p_done) && (bus.burst_count == 0);
            for (int i = 0; i < PORTS; i++) begin
                if (!p_rst || !p_req[i] || bus.grant[i]) begin
                    wait_cnt[i] = 0;
                end else if (new_ten) begin
                    wait_cnt[i]++;
                    check("no_starve", 32'(wait_cnt[i] <= PORTS-1), 1);
                end
            end
        end
        p_rst   = rst;
        p_valid = bus.grant_valid;
        p_done  = bus.done;
        p_req   = bus.request;
        p_grant = bus.grant;
        p_enc   = bus.grant_encoded;
        p_bc    = bus.burst_count;
    end

    initial begin
        logic [1:0] exp_enc [9];
        exp_enc = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

        // Reset state
        bus.request = '0;
        bus.done    = 1'b0;
        bus.weight  = '0;
        rst = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        check_out("reset", 4'b0000, 1'b0, 2'd0, 4'd0);

        // First grant after reset searches from port 0
        rst = 1'b1;
        bus.request = 4'b1010;
        tick();
        check_out("first", 4'b0010, 1'b1, 2'd1, 4'd0);

        // Tenure ends with nobody requesting -> idle
        bus.request = 4'b0000;
        bus.done    = 1'b1;
        tick();
        check_out("to_idle", 4'b0000, 1'b0, 2'd0, 4'd0);

        // done while idle is ignored
        tick();
        check_out("idle_done", 4'b0000, 1'b0, 2'd0, 4'd0);

        // Weight 2 on all ports, everyone requesting, done every cycle
        bus.done = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.weight  = 16'h2222;
        bus.request = 4'b1111;
        tick();
        check_out("wrr_0", 4'b0001, 1'b1, 2'd0, 4'd0);
        bus.done = 1'b1;
        for (int k = 1; k < 9; k++) begin
            tick();
            check_out($sformatf("wrr_%0d", k), 4'b0001 << exp_enc[k], 1'b1, exp_enc[k], 4'(k % 2));
        end

        // Port 2 with weight 3 loses its request after the first done
        bus.done = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.weight  = 16'h0300;
        bus.request = 4'b0100;
        tick();
        check_out("p2_start", 4'b0100, 1'b1, 2'd2, 4'd0);
        bus.request = 4'b0101;
        bus.done    = 1'b1;
        tick();
        check_out("p2_keep", 4'b0100, 1'b1, 2'd2, 4'd1);
        bus.request = 4'b0001;
        bus.done    = 1'b0;
        tick();
        check_out("p2_hold", 4'b0100, 1'b1, 2'd2, 4'd1);
        bus.done = 1'b1;
        tick();
        check_out("p2_move", 4'b0001, 1'b1, 2'd0, 4'd0);

        // Only port 3, weight 1: continuous re-grant with no gap
        bus.request = 4'b1000;
        bus.weight  = 16'h1000;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("solo_%0d", k), 4'b1000, 1'b1, 2'd3, 4'd0);
        end

        // Reset mid-tenure together with done
        rst = 1'b0;
        tick();
        check_out("mid_reset", 4'b0000, 1'b0, 2'd0, 4'd0);
        rst = 1'b1;
        bus.done    = 1'b0;
        bus.request = 4'b1111;
        tick();
        check_out("post_reset", 4'b0001, 1'b1, 2'd0, 4'd0);

        // Random stimulus; the falling-edge monitor checks every cycle
        for (int k = 0; k < 800; k++) begin
            bus.request = 4'($urandom_range(0, 15));
            bus.done    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bus.weight = 16'($urandom());
            rst = ($urandom_range(0, 60) != 0);
            tick();
        end
        rst = 1'b1;
        tick();
        check("cover_enc", enc_seen, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
